// File: rtl/uart_rx_core_if.sv
// Receive-side bundle between uart_rx_core and its consumer (serial line in,
// held byte/valid/ack handshake and error flags out).
interface uart_rx_core_if;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    modport master (
        input  rx,
        input  rx_ack,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        output busy
    );

    modport slave (
        output rx,
        output rx_ack,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises rx, finds the start edge, samples each bit at
// its centre and hands the byte over on a held valid/ack interface.
module uart_rx_core #(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic           clk_in,
    input  logic           rst,
    uart_rx_core_if.master bus
);
    localparam int unsigned BIT_CYC  = CLK_FREQ / BAUD;
    localparam int unsigned HALF_CYC = BIT_CYC / 2;
    localparam int unsigned CNT_W    = $clog2(BIT_CYC);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_e;

    state_e            state_q,     state_d;
    logic              sync1_q,     sync1_d;
    logic              rx_s_q,      rx_s_d;
    logic              rx_prev_q,   rx_prev_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [2:0]        bit_idx_q,   bit_idx_d;
    logic [7:0]        shift_q,     shift_d;
    logic [7:0]        rx_data_q,   rx_data_d;
    logic              rx_valid_q,  rx_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q,   overrun_d;

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        sync1_d     = bus.rx;
        rx_s_d      = sync1_q;
        rx_prev_d   = rx_s_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;

        if (bus.rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // A line back high at the start centre was only a glitch.
                    state_d   = rx_s_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        // A coincident ack lets the new byte win without an overrun.
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q && !bus.rx_ack) begin
                            overrun_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun_err = overrun_q;
    assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a fast instance (16 cycles/bit) for the scenarios and
// two default-rate instances for the full-rate latency check.
module tb_uart_rx_core;
    localparam int SB      = 16;
    localparam int SLAT    = 2 + 8 + 9 * 16;
    localparam int DB      = 5208;
    localparam int DLAT    = 2 + 2604 + 9 * 5208;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   checks;
    int   errors;

    uart_rx_core_if if_a ();
    uart_rx_core_if if_b0 ();
    uart_rx_core_if if_b1 ();

    uart_rx_core #(.CLK_FREQ(160), .BAUD(10)) u_a (.clk_in(clk), .rst(rst_a), .bus(if_a.master));
    uart_rx_core u_b0 (.clk_in(clk), .rst(rst_b), .bus(if_b0.master));
    uart_rx_core u_b1 (.clk_in(clk), .rst(rst_b), .bus(if_b1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors sampled on the falling edge.
    int   fe_a, fe_b, rise_a, rise_b0, rise_b1;
    logic pv_a, pv_b0, pv_b1;
    initial begin
        fe_a = 0; fe_b = 0; rise_a = -1; rise_b0 = -1; rise_b1 = -1;
        pv_a = 1'b0; pv_b0 = 1'b0; pv_b1 = 1'b0;
    end
    always @(negedge clk) begin
        if (if_a.frame_err === 1'b1) fe_a = fe_a + 1;
        if (if_b0.frame_err === 1'b1 || if_b1.frame_err === 1'b1) fe_b = fe_b + 1;
        if (if_a.rx_valid === 1'b1 && pv_a !== 1'b1) rise_a = cyc;
        if (if_b0.rx_valid === 1'b1 && pv_b0 !== 1'b1) rise_b0 = cyc;
        if (if_b1.rx_valid === 1'b1 && pv_b1 !== 1'b1) rise_b1 = cyc;
        pv_a  = if_a.rx_valid;
        pv_b0 = if_b0.rx_valid;
        pv_b1 = if_b1.rx_valid;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    int a_start;

    task automatic drive_a(input logic v, input int n);
        if_a.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, then the given stop level; line left at stop level.
    task automatic send_a(input logic [7:0] d, input logic stop_bit);
        a_start = cyc;
        drive_a(1'b0, SB);
        for (int i = 0; i < 8; i++) drive_a(d[i], SB);
        drive_a(stop_bit, SB);
    endtask

    task automatic ack_a();
        if_a.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        if_a.rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        checks++; if (if_a.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", if_a.rx_data); end
        checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_a.rx_valid); end
        checks++; if (if_a.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b exp 0", if_a.frame_err); end
        checks++; if (if_a.overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", if_a.overrun_err); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", if_a.busy); end
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_frame();
        rise_a = -1;
        send_a(8'hA5, 1'b1);
        @(negedge clk);
        checks++; if (if_a.rx_valid !== 1'b1) begin errors++; $display("FAIL frame_valid: got %b exp 1", if_a.rx_valid); end
        checks++; if (if_a.rx_data !== 8'hA5) begin errors++; $display("FAIL frame_data: got %h exp a5", if_a.rx_data); end
        checks++; if (fe_a !== 0) begin errors++; $display("FAIL frame_no_ferr: got %0d pulses exp 0", fe_a); end
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after: got %b exp 0", if_a.busy); end
        checks++; if (rise_a < 0 || rise_a - a_start < SLAT - 2 || rise_a - a_start > SLAT + 2) begin
            errors++; $display("FAIL frame_latency: got %0d cycles exp %0d +-2", rise_a - a_start, SLAT); end
        ack_a();
        @(negedge clk);
        checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL frame_ack_clear: got %b exp 0", if_a.rx_valid); end
    endtask

    task automatic test_glitch();
        int fe0;
        fe0 = fe_a;
        drive_a(1'b0, 3);
        if_a.rx = 1'b1;
        @(negedge clk);
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b exp 1", if_a.busy); end
        repeat (20) @(negedge clk);
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b exp 0", if_a.busy); end
        checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b exp 0", if_a.rx_valid); end
        checks++; if (if_a.overrun_err !== 1'b0) begin errors++; $display("FAIL glitch_overrun: got %b exp 0", if_a.overrun_err); end
        checks++; if (fe_a !== fe0) begin errors++; $display("FAIL glitch_ferr: got %0d pulses exp %0d", fe_a, fe0); end
    endtask

    task automatic test_frame_err();
        int fe0;
        fe0 = fe_a;
        send_a(8'h3C, 1'b0);
        drive_a(1'b0, 40);
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low: got %b exp 1", if_a.busy); end
        checks++; if (fe_a !== fe0 + 1) begin errors++; $display("FAIL ferr_pulse: got %0d pulses exp %0d", fe_a - fe0, 1); end
        checks++; if (if_a.rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b exp 0", if_a.rx_valid); end
        drive_a(1'b1, 20);
        checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL ferr_no_false_start: got busy %b exp 0", if_a.busy); end
        send_a(8'h81, 1'b1);
        @(negedge clk);
        checks++; if (if_a.rx_data !== 8'h81 || if_a.rx_valid !== 1'b1) begin
            errors++; $display("FAIL ferr_recover: got %h/%b exp 81/1", if_a.rx_data, if_a.rx_valid); end
        checks++; if (fe_a !== fe0 + 1) begin errors++; $display("FAIL ferr_single: got %0d pulses exp 1", fe_a - fe0); end
        ack_a();
    endtask

    task automatic test_back_to_back();
        send_a(8'h11, 1'b1);
        send_a(8'h22, 1'b1);
        @(negedge clk);
        checks++; if (if_a.rx_data !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h exp 22", if_a.rx_data); end
        checks++; if (if_a.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b exp 1", if_a.rx_valid); end
        checks++; if (if_a.overrun_err !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b exp 1", if_a.overrun_err); end
        ack_a();
        @(negedge clk);
        checks++; if (if_a.rx_valid !== 1'b0 || if_a.overrun_err !== 1'b0) begin
            errors++; $display("FAIL b2b_ack_clear: got valid %b ovr %b exp 0/0", if_a.rx_valid, if_a.overrun_err); end
    endtask

    // Ack lands on the same edge the next byte completes: new byte kept, no overrun.
    task automatic test_ack_collision();
        send_a(8'h33, 1'b1);
        fork
            send_a(8'h44, 1'b1);
            begin
                repeat (SLAT) @(posedge clk);
                #1;
                if_a.rx_ack = 1'b1;
                @(posedge clk);
                #1;
                if_a.rx_ack = 1'b0;
            end
        join
        @(negedge clk);
        checks++; if (if_a.rx_data !== 8'h44 || if_a.rx_valid !== 1'b1) begin
            errors++; $display("FAIL coll_new_byte: got %h/%b exp 44/1", if_a.rx_data, if_a.rx_valid); end
        checks++; if (if_a.overrun_err !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b exp 0", if_a.overrun_err); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int fe0;
        d = 8'hF0;
        drive_a(1'b0, SB);
        for (int i = 0; i < 4; i++) drive_a(d[i], SB);
        drive_a(d[4], SB / 2);
        checks++; if (if_a.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b exp 1", if_a.busy); end
        #2;
        rst_a = 1'b1;
        #1;
        checks++; if (if_a.rx_data !== 8'h00 || if_a.rx_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_async_out: got %h/%b exp 00/0", if_a.rx_data, if_a.rx_valid); end
        checks++; if (if_a.busy !== 1'b0 || if_a.overrun_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_async_busy: got busy %b ovr %b exp 0/0", if_a.busy, if_a.overrun_err); end
        if_a.rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        fe0 = fe_a;
        drive_a(1'b1, 5);
        send_a(8'h5A, 1'b1);
        @(negedge clk);
        checks++; if (if_a.rx_data !== 8'h5A || if_a.rx_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_next: got %h/%b exp 5a/1", if_a.rx_data, if_a.rx_valid); end
        checks++; if (fe_a !== fe0 || if_a.overrun_err !== 1'b0) begin
            errors++; $display("FAIL rstmid_errs: got ferr %0d ovr %b exp 0/0", fe_a - fe0, if_a.overrun_err); end
        ack_a();
    endtask

    // Random frames, stop faults and acks against a byte-level model.
    task automatic test_random();
        logic [7:0] d;
        logic [7:0] exp_data;
        logic       exp_valid, exp_ovr, bad;
        int         exp_fe;
        exp_data = 8'h5A; exp_valid = 1'b0; exp_ovr = 1'b0; exp_fe = fe_a;
        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_a(d, !bad);
            if (bad) begin
                drive_a(1'b0, $urandom_range(1, 30));
                exp_fe++;
            end else begin
                exp_ovr   = exp_ovr | exp_valid;
                exp_valid = 1'b1;
                exp_data  = d;
            end
            drive_a(1'b1, $urandom_range(2, 20));
            @(negedge clk);
            checks++; if (if_a.rx_data !== exp_data || if_a.rx_valid !== exp_valid || if_a.overrun_err !== exp_ovr) begin
                errors++; $display("FAIL rand_%0d: got data %h valid %b ovr %b exp %h %b %b", n,
                                   if_a.rx_data, if_a.rx_valid, if_a.overrun_err, exp_data, exp_valid, exp_ovr); end
            checks++; if (fe_a !== exp_fe) begin errors++; $display("FAIL rand_ferr_%0d: got %0d exp %0d", n, fe_a, exp_fe); end
            if ($urandom_range(0, 1) == 1) begin
                ack_a();
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
            end
        end
        if (exp_valid) ack_a();
    endtask

    task automatic drive_b(input logic v0, input logic v1, input int n);
        if_b0.rx = v0;
        if_b1.rx = v1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full-rate instances receive 0x00 and 0xFF side by side.
    task automatic test_default_rate();
        logic [7:0] d0, d1;
        int b_start;
        d0 = 8'h00; d1 = 8'hFF;
        b_start = cyc;
        drive_b(1'b0, 1'b0, DB);
        for (int i = 0; i < 8; i++) drive_b(d0[i], d1[i], DB);
        drive_b(1'b1, 1'b1, DB);
        @(negedge clk);
        checks++; if (if_b0.rx_data !== 8'h00 || if_b0.rx_valid !== 1'b1) begin
            errors++; $display("FAIL dflt_00: got %h/%b exp 00/1", if_b0.rx_data, if_b0.rx_valid); end
        checks++; if (if_b1.rx_data !== 8'hFF || if_b1.rx_valid !== 1'b1) begin
            errors++; $display("FAIL dflt_ff: got %h/%b exp ff/1", if_b1.rx_data, if_b1.rx_valid); end
        checks++; if (rise_b0 < 0 || rise_b0 - b_start < DLAT - 2 || rise_b0 - b_start > DLAT + 2) begin
            errors++; $display("FAIL dflt_lat_00: got %0d exp %0d +-2", rise_b0 - b_start, DLAT); end
        checks++; if (rise_b1 < 0 || rise_b1 - b_start < DLAT - 2 || rise_b1 - b_start > DLAT + 2) begin
            errors++; $display("FAIL dflt_lat_ff: got %0d exp %0d +-2", rise_b1 - b_start, DLAT); end
        checks++; if (fe_b !== 0 || if_b0.overrun_err !== 1'b0 || if_b1.overrun_err !== 1'b0) begin
            errors++; $display("FAIL dflt_errs: got ferr %0d ovr %b %b exp 0", fe_b, if_b0.overrun_err, if_b1.overrun_err); end
        if_b0.rx_ack = 1'b1;
        if_b1.rx_ack = 1'b1;
        @(posedge clk);
        #1;
        if_b0.rx_ack = 1'b0;
        if_b1.rx_ack = 1'b0;
        @(negedge clk);
        checks++; if (if_b0.rx_valid !== 1'b0 || if_b1.rx_valid !== 1'b0) begin
            errors++; $display("FAIL dflt_ack: got %b %b exp 0 0", if_b0.rx_valid, if_b1.rx_valid); end
        checks++; if (if_b0.busy !== 1'b0 || if_b1.busy !== 1'b0) begin
            errors++; $display("FAIL dflt_busy: got %b %b exp 0 0", if_b0.busy, if_b1.busy); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        if_a.rx = 1'b1;  if_a.rx_ack = 1'b0;
        if_b0.rx = 1'b1; if_b0.rx_ack = 1'b0;
        if_b1.rx = 1'b1; if_b1.rx_ack = 1'b0;
        test_reset();
        test_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_ack_collision();
        test_reset_midframe();
        test_random();
        test_default_rate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver: the receive-side counterpart of the team's UART transmit path and its baud clock divider.
- Synchronises the asynchronous serial line and detects the start bit.
- Samples each bit at its centre using a free-running bit-period counter, checks the stop bit, and presents the received byte on a held valid/ack interface to the uart_controller.
- Reports framing and overrun errors.

Parameters:
- CLK_FREQ, 50000000, input clock frequency in Hz (50 MHz board clock).
- BAUD, 9600, line rate in bits/s.
- BIT_CYC, CLK_FREQ/BAUD (integer truncation, 5208 at defaults), clock cycles per bit. Derived; must be >= 4.
- HALF_CYC, BIT_CYC/2 (2604 at defaults), cycles from the falling edge to the start-bit centre. Derived.

Ports:
- clk_in  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk_in.
- rx_ack  input  1  consumer acknowledge; a 1-cycle pulse clears rx_valid and overrun_err.
- rx_data  output  8  last received byte, LSB first on the line.
- rx_valid  output  1  byte available; held until rx_ack.
- frame_err  output  1  1-cycle pulse when the stop bit is sampled low.
- overrun_err  output  1  sticky; a new byte completed while rx_valid was high and not acked.
- busy  output  1  high while state != IDLE.

Behaviour:
- Reset (async assert, sync use):
  - Synchroniser flops and rx_prev = 1.
  - state = IDLE; counter = 0; bit_idx = 0; shift = 0.
  - rx_data = 0x00; rx_valid = 0; frame_err = 0; overrun_err = 0; busy = 0.
  - Reset mid-frame abandons the frame silently, with no error pulse.
- Synchroniser: rx passes through two flops to give rx_s. rx_prev registers rx_s. All decisions use rx_s, so there is 2 cycles of input latency.
- Counter width: $clog2(BIT_CYC) bits; it never exceeds BIT_CYC-1.
- IDLE:
  - On rx_prev == 1 and rx_s == 0, go to START with counter = 0.
- START:
  - Increment the counter.
  - When counter == HALF_CYC-1, sample rx_s.
    - If 0, go to DATA with counter = 0 and bit_idx = 0.
    - If 1, treat it as a glitch and return to IDLE with no outputs asserted.
- DATA:
  - Increment the counter.
  - When counter == BIT_CYC-1:
    - shift <= {rx_s, shift[7:1]} (LSB first).
    - counter = 0 and bit_idx += 1.
  - After the 8th sample (bit_idx == 7 at the sample), go to STOP.
- STOP:
  - Same cadence as DATA. At counter == BIT_CYC-1, sample rx_s.
  - Stop = 1:
    - rx_data <= shift and rx_valid <= 1.
    - If rx_valid was already 1 and rx_ack is not high this cycle, overrun_err <= 1 (old byte overwritten).
    - Go to IDLE at the stop-bit centre, so the next start edge is caught.
  - Stop = 0:
    - frame_err pulses high for 1 cycle; rx_data and rx_valid are unchanged.
    - Go to WAIT_IDLE.
- WAIT_IDLE (break/noise recovery):
  - Stay until rx_s == 1, then go to IDLE.
  - rx_prev tracking ensures that no false start is taken from a held-low line.
- rx_ack:
  - Clears rx_valid and overrun_err in the cycle after it is sampled.
  - If rx_ack coincides with a new byte completing, the new byte wins: rx_valid stays 1 and no overrun is flagged.
  - rx_ack while rx_valid == 0 has no effect.
- busy: combinational from state; high in START, DATA, STOP and WAIT_IDLE.
- rx activity while busy is ignored except through the sampling points.
- Latency:
  - rx_valid rises 2 + HALF_CYC + 9*BIT_CYC cycles (±1 for the edge-detect register) after the start falling edge at the rx pin.
  - The bench must check against a window of ±2 cycles.

Test Plan:
(All scenarios use CLK_FREQ=160 and BAUD=10, giving BIT_CYC=16 and HALF_CYC=8, unless noted.)
1. Frame 0xA5 with a good stop bit -> rx_valid=1, rx_data=0xA5, frame_err=0, busy low after the stop centre. rx_ack pulse -> rx_valid=0 next cycle.
2. rx low for 3 cycles, then high (glitch) -> state back to IDLE after the start-centre sample; rx_valid, frame_err and overrun_err all stay 0.
3. Frame 0x3C with the stop bit driven 0, line held low 40 cycles then high -> one frame_err pulse, rx_valid=0, no second start detected while low. A following 0x81 frame is received correctly.
4. Frames 0x11 then 0x22 back-to-back without ack -> rx_data=0x22, rx_valid=1, overrun_err=1. rx_ack -> both cleared.
5. rst pulsed during data bit 4 of 0xF0 -> all outputs 0 immediately (async), busy=0. A following frame 0x5A gives rx_data=0x5A with no errors.
6. Default parameters (BIT_CYC=5208): frames 0x00 and 0xFF, each acked -> both received; rx_valid rise within ±2 cycles of the latency formula.
